tpsram_stream_fifo_ctrl: RTL and testbench
==========================================

// Module: tpsram_stream_fifo_ctrl
// PURPOSE
//  Ring-buffer controller that turns the 16384x8 two-port TPSRAM into a valid/ready streaming FIFO.
//  Owns the RAM write port (B) and read port (A), drives all RAM addresses and enables, and hides
//  the RAM's 1-cycle read latency behind a 2-entry output buffer. Sits between a byte producer
//  and a byte consumer in the same clock domain. Sustains 1 word/cycle in and out.
// PARAMETERS
//  ADDR_W         14     RAM address width; DEPTH = 2**ADDR_W = 16384
//  DATA_W         8      word width
//  AFULL_THRESH   16320  AFULL asserts when LEVEL >= value
//  AEMPTY_THRESH  64     AEMPTY asserts when LEVEL <= value
// PORTS
//  CLK         in   1         single clock; RAM uses the same CLK
//  RESET       in   1         asynchronous, active-high
//  IN_DATA     in   DATA_W    producer word
//  IN_VALID    in   1         producer valid
//  IN_READY    out  1         controller can accept
//  OUT_DATA    out  DATA_W    consumer word
//  OUT_VALID   out  1         OUT_DATA valid
//  OUT_READY   in   1         consumer accepts
//  FLUSH       in   1         synchronous single-cycle clear
//  LEVEL       out  ADDR_W+1  words accepted and not yet delivered (RAM + buffer + in flight)
//  AFULL       out  1         LEVEL >= AFULL_THRESH
//  AEMPTY      out  1         LEVEL <= AEMPTY_THRESH
//  RAM_W_DATA  out  DATA_W    to RAM W_DATA
//  RAM_W_ADDR  out  ADDR_W    to RAM W_ADDR
//  RAM_W_EN    out  1         to RAM W_EN
//  RAM_R_ADDR  out  ADDR_W    to RAM R_ADDR
//  RAM_R_EN    out  1         to RAM R_EN
//  RAM_R_DATA  in   DATA_W    from RAM R_DATA, valid the cycle after the RAM_R_EN edge
// BEHAVIOUR
//  Reset: wr_ptr=rd_ptr=0, buffer empty, inflight=0, IN_READY=0, OUT_VALID=0, OUT_DATA=0, LEVEL=0,
//   AFULL=0, AEMPTY=1, RAM_W_EN=0, RAM_R_EN=0, addresses 0. IN_READY goes 1 at the first edge after release.
//  Pointers: wr_ptr/rd_ptr are ADDR_W+1 bits (wrap bit). RAM occupancy = wr_ptr - rd_ptr, mod 2**(ADDR_W+1).
//   Addresses use ptr[ADDR_W-1:0]; natural wrap 16383->0.
//  Write: accept = IN_VALID & IN_READY. RAM_W_EN=accept, RAM_W_ADDR=wr_ptr, RAM_W_DATA=IN_DATA (combinational).
//   wr_ptr++ on accept. IN_READY is registered: 0 when the next occupancy will equal DEPTH, or FLUSH, or reset.
//  Read issue: RAM_R_EN=1 when occupancy != 0 (registered wr_ptr, so a word written at edge k is readable
//   no earlier than edge k+1; no same-address read/write collision) and (buf_cnt + inflight - pop) < 2.
//   RAM_R_ADDR=rd_ptr; rd_ptr++ on issue. inflight set for one cycle; RAM_R_DATA pushed into buffer next edge.
//  Output buffer: 2-entry FIFO; OUT_VALID = buf_cnt!=0; pop = OUT_VALID & OUT_READY.
//   OUT_DATA held stable while OUT_VALID & !OUT_READY.
//  Latency: word accepted at edge k -> OUT_VALID=1 after edge k+2 when the FIFO was empty.
//  Capacity: DEPTH in RAM + 2 in buffer = 16386 words before IN_READY=0 with OUT_READY held 0.
//  LEVEL: +1 on accept, -1 on pop, unchanged on simultaneous accept+pop; registered.
//  FLUSH (edge k): pointers, buffer, inflight, LEVEL cleared at edge k. In-flight RAM_R_DATA dropped.
//   IN_READY=0 and RAM_R_EN=0 during the FLUSH cycle, so nothing is accepted. OUT_VALID=0 after edge k.
//  RESET mid-operation: all state returns to reset values immediately (asynchronous); RAM contents are not cleared.
// STRUCTURE
//  Package tpsram_ctrl_pkg: ADDR_W, DATA_W, DEPTH constants; ptr_t (ADDR_W+1 bits); level_t.
//  Sub-module tpsram_out_buf: 2-entry output FIFO with push/pop/cnt, async active-high RESET.
//  Top: pointer/occupancy logic, read-issue logic, LEVEL/flag registers.
// TESTING
//  1 Release reset, write 0xA5 at edge k with OUT_READY=1 -> RAM_W_EN=1, addr 0; OUT_VALID from edge k+2,
//    OUT_DATA=0xA5; LEVEL 1 then 0; AEMPTY stays 1.
//  2 OUT_READY=0, IN_VALID=1 with incrementing data -> exactly 16386 accepted, then IN_READY=0.
//    AFULL from LEVEL=16320, LEVEL=16386; then drain all -> data 0..16385 in order (mod 256).
//  3 Both sides always ready, 1000 incrementing words -> after the 2-cycle fill, one word per cycle,
//    no OUT_VALID gaps, order preserved.
//  4 20000 words with random IN_VALID/OUT_READY (50%) -> scoreboard match across pointer wrap;
//    OUT_DATA stable during every stall.
//  5 LEVEL=100 with a read in flight, FLUSH=1 with IN_VALID=1, IN_DATA=0x3C -> word not accepted.
//    LEVEL=0, OUT_VALID=0 after the edge; the next write 0x11 is the next word out.
//  6 RESET pulsed mid-stream (LEVEL=500) -> all outputs at reset values while RESET=1.
//    After release, a new write/read pair round-trips correctly.

Source files
------------

// File: rtl/tpsram_ctrl_pkg.sv
// Shared constants and types for the TPSRAM streaming FIFO controller.
// Pointers and LEVEL carry one extra bit so that a full RAM can be told apart from an empty one.
package tpsram_ctrl_pkg;

  localparam int ADDR_W        = 14;
  localparam int DATA_W        = 8;
  localparam int DEPTH         = 2 ** ADDR_W;
  localparam int AFULL_THRESH  = 16320;
  localparam int AEMPTY_THRESH = 64;

  typedef logic [ADDR_W:0]   ptr_t;
  typedef logic [ADDR_W:0]   level_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/tpsram_out_buf.sv
// Two-entry output FIFO that absorbs the RAM read latency.
// The head entry drives out_data directly, so the word stays stable while the consumer stalls.
module tpsram_out_buf
  import tpsram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  data_t      push_data,
  input  logic       pop,
  output data_t      out_data,
  output logic       out_valid,
  output logic [1:0] cnt
);

  data_t      mem_q [2];
  data_t      mem_d [2];
  logic       wr_idx_q, wr_idx_d;
  logic       rd_idx_q, rd_idx_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_idx_d = 1'b0;
      rd_idx_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_idx_q] = push_data;
        wr_idx_d        = ~wr_idx_q;
      end
      if (pop) begin
        rd_idx_d = ~rd_idx_q;
      end
      cnt_d = cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_data  = mem_q[rd_idx_q];
  assign out_valid = (cnt_q != 2'd0);
  assign cnt       = cnt_q;

endmodule

// File: rtl/tpsram_stream_fifo_ctrl.sv
// Ring-buffer controller turning the 16384x8 two-port TPSRAM into a valid/ready byte FIFO.
// Reads are issued ahead into a 2-entry buffer so the consumer sees one word per cycle.
module tpsram_stream_fifo_ctrl
  import tpsram_ctrl_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  input  logic              FLUSH,
  output logic [ADDR_W:0]   LEVEL,
  output logic              AFULL,
  output logic              AEMPTY,
  output logic [DATA_W-1:0] RAM_W_DATA,
  output logic [ADDR_W-1:0] RAM_W_ADDR,
  output logic              RAM_W_EN,
  output logic [ADDR_W-1:0] RAM_R_ADDR,
  output logic              RAM_R_EN,
  input  logic [DATA_W-1:0] RAM_R_DATA
);

  localparam ptr_t   DEPTH_PTR  = ptr_t'(DEPTH);
  localparam level_t AFULL_LVL  = level_t'(AFULL_THRESH);
  localparam level_t AEMPTY_LVL = level_t'(AEMPTY_THRESH);

  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  level_t     level_q, level_d;
  logic       in_ready_q, in_ready_d;
  logic       inflight_q, inflight_d;
  logic       afull_q, afull_d;
  logic       aempty_q, aempty_d;

  ptr_t       occ;
  ptr_t       occ_next;
  logic       accept;
  logic       issue;
  logic       pop;
  logic       push;
  logic [1:0] buf_cnt;
  logic [2:0] slots_used;

  // Occupancy uses the registered write pointer, so a word is never read in the cycle it is written.
  always_comb begin
    accept     = IN_VALID & in_ready_q & ~FLUSH;
    pop        = OUT_VALID & OUT_READY;
    push       = inflight_q & ~FLUSH;
    occ        = wr_ptr_q - rd_ptr_q;
    slots_used = 3'(buf_cnt) + 3'(inflight_q) - 3'(pop);
    issue      = (occ != '0) && (slots_used < 3'd2) && !FLUSH;
    occ_next   = occ + ptr_t'(accept) - ptr_t'(issue);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    inflight_d = 1'b0;
    in_ready_d = 1'b0;
    if (!FLUSH) begin
      wr_ptr_d   = wr_ptr_q + ptr_t'(accept);
      rd_ptr_d   = rd_ptr_q + ptr_t'(issue);
      level_d    = level_q + level_t'(accept) - level_t'(pop);
      inflight_d = issue;
      in_ready_d = (occ_next != DEPTH_PTR);
    end else begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    afull_d  = (level_d >= AFULL_LVL);
    aempty_d = (level_d <= AEMPTY_LVL);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b0;
      inflight_q <= 1'b0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      in_ready_q <= in_ready_d;
      inflight_q <= inflight_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
    end
  end

  tpsram_out_buf u_out_buf (
    .clk       (CLK),
    .rst       (RESET),
    .flush     (FLUSH),
    .push      (push),
    .push_data (RAM_R_DATA),
    .pop       (pop),
    .out_data  (OUT_DATA),
    .out_valid (OUT_VALID),
    .cnt       (buf_cnt)
  );

  assign IN_READY   = in_ready_q & ~FLUSH;
  assign RAM_W_EN   = accept;
  assign RAM_W_ADDR = wr_ptr_q[ADDR_W-1:0];
  assign RAM_W_DATA = IN_DATA;
  assign RAM_R_EN   = issue;
  assign RAM_R_ADDR = rd_ptr_q[ADDR_W-1:0];
  assign LEVEL      = level_q;
  assign AFULL      = afull_q;
  assign AEMPTY     = aempty_q;

endmodule

// File: tb/tb_tpsram_stream_fifo_ctrl.sv
// Bench for the TPSRAM streaming FIFO controller: a behavioural RAM plus a queue-based
// reference model of the words accepted and still owed to the consumer.
module tb_tpsram_stream_fifo_ctrl;
  import tpsram_ctrl_pkg::*;

  localparam int CAPACITY = DEPTH + 2;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic [DATA_W-1:0] IN_DATA = '0;
  logic              IN_VALID = 1'b0;
  logic              IN_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_READY = 1'b0;
  logic              FLUSH = 1'b0;
  logic [ADDR_W:0]   LEVEL;
  logic              AFULL;
  logic              AEMPTY;
  logic [DATA_W-1:0] RAM_W_DATA;
  logic [ADDR_W-1:0] RAM_W_ADDR;
  logic              RAM_W_EN;
  logic [ADDR_W-1:0] RAM_R_ADDR;
  logic              RAM_R_EN;
  logic [DATA_W-1:0] RAM_R_DATA;

  tpsram_stream_fifo_ctrl dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IN_DATA    (IN_DATA),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .FLUSH      (FLUSH),
    .LEVEL      (LEVEL),
    .AFULL      (AFULL),
    .AEMPTY     (AEMPTY),
    .RAM_W_DATA (RAM_W_DATA),
    .RAM_W_ADDR (RAM_W_ADDR),
    .RAM_W_EN   (RAM_W_EN),
    .RAM_R_ADDR (RAM_R_ADDR),
    .RAM_R_EN   (RAM_R_EN),
    .RAM_R_DATA (RAM_R_DATA)
  );

  always #5 CLK = ~CLK;

  // Two-port RAM with one cycle of read latency; contents survive reset.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge CLK) begin
    if (RAM_W_EN) ram[RAM_W_ADDR] <= RAM_W_DATA;
    if (RAM_R_EN) RAM_R_DATA <= ram[RAM_R_ADDR];
  end

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] model_q [$];

  int          cyc = 0;
  int          acc_count = 0;
  int          pop_count = 0;
  int          first_acc_cyc = 0;
  int          first_pop_cyc = 0;
  int          last_pop_cyc = 0;
  logic [7:0]  last_pop_data = '0;
  logic        s_in_ready, s_out_valid, s_w_en, s_r_en, s_acc, s_pop;
  logic [7:0]  s_out_data, s_in_data;
  logic [13:0] s_w_addr;
  logic        stall_armed = 1'b0;
  logic [7:0]  held_data = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rdy, input logic fl);
    IN_VALID  = v;
    IN_DATA   = d;
    OUT_READY = rdy;
    FLUSH     = fl;
  endtask

  task automatic clearCounters();
    acc_count = 0;
    pop_count = 0;
  endtask

  // One clock: sample handshakes mid-cycle, then update the reference model after the edge.
  task automatic step();
    @(negedge CLK);
    s_in_ready  = IN_READY;
    s_out_valid = OUT_VALID;
    s_out_data  = OUT_DATA;
    s_in_data   = IN_DATA;
    s_w_en      = RAM_W_EN;
    s_w_addr    = RAM_W_ADDR;
    s_r_en      = RAM_R_EN;
    s_acc       = IN_VALID && IN_READY;
    s_pop       = OUT_VALID && OUT_READY;
    if (stall_armed) begin
      checkOutput("stall_valid", s_out_valid, 1);
      checkOutput("stall_data", s_out_data, held_data);
    end
    stall_armed = OUT_VALID && !OUT_READY && !FLUSH;
    held_data   = OUT_DATA;
    @(posedge CLK);
    #1;
    cyc++;
    if (FLUSH) begin
      model_q.delete();
    end else begin
      if (s_pop) begin
        if (model_q.size() == 0) begin
          checkOutput("spurious_valid", s_out_valid, 0);
        end else begin
          checkOutput("out_data", s_out_data, model_q.pop_front());
        end
        if (pop_count == 0) first_pop_cyc = cyc;
        last_pop_cyc  = cyc;
        last_pop_data = s_out_data;
        pop_count++;
      end
      if (s_acc) begin
        model_q.push_back(s_in_data);
        if (acc_count == 0) first_acc_cyc = cyc;
        acc_count++;
      end
    end
    checkOutput("level", LEVEL, model_q.size());
    checkOutput("afull", AFULL, model_q.size() >= AFULL_THRESH);
    checkOutput("aempty", AEMPTY, model_q.size() <= AEMPTY_THRESH);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, IN_READY, 0);
    checkOutput({tag, "_out_valid"}, OUT_VALID, 0);
    checkOutput({tag, "_out_data"}, OUT_DATA, 0);
    checkOutput({tag, "_level"}, LEVEL, 0);
    checkOutput({tag, "_afull"}, AFULL, 0);
    checkOutput({tag, "_aempty"}, AEMPTY, 1);
    checkOutput({tag, "_w_en"}, RAM_W_EN, 0);
    checkOutput({tag, "_r_en"}, RAM_R_EN, 0);
    checkOutput({tag, "_w_addr"}, RAM_W_ADDR, 0);
    checkOutput({tag, "_r_addr"}, RAM_R_ADDR, 0);
  endtask

  initial begin
    int n;
    logic afull_seen;
    int afull_level;

    // Reset values and release
    #1 RESET = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    @(posedge CLK); @(posedge CLK); #1;
    checkResetOutputs("reset");
    RESET = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    checkOutput("ready_before_first_edge", s_in_ready, 0);
    checkOutput("ready_after_first_edge", IN_READY, 1);

    // Single word round trip
    clearCounters();
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
    step();
    checkOutput("t1_w_en", s_w_en, 1);
    checkOutput("t1_w_addr", s_w_addr, 0);
    checkOutput("t1_accept", s_acc, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    checkOutput("t1_valid_k1", OUT_VALID, 0);
    step();
    checkOutput("t1_valid_k2", OUT_VALID, 1);
    checkOutput("t1_data_k2", OUT_DATA, 8'hA5);
    step();
    checkOutput("t1_popped", pop_count, 1);
    checkOutput("t1_valid_after", OUT_VALID, 0);

    // Capacity fill with consumer stalled, then drain
    clearCounters();
    afull_seen = 1'b0;
    afull_level = 0;
    for (int i = 0; i < CAPACITY + 20; i++) begin
      applyStimulus(1'b1, acc_count[7:0], 1'b0, 1'b0);
      step();
      if (AFULL && !afull_seen) begin
        afull_seen = 1'b1;
        afull_level = int'(LEVEL);
      end
    end
    checkOutput("t2_accepted", acc_count, CAPACITY);
    checkOutput("t2_in_ready_full", IN_READY, 0);
    checkOutput("t2_level_full", LEVEL, CAPACITY);
    checkOutput("t2_afull_rise", afull_level, AFULL_THRESH);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    n = 0;
    while (model_q.size() != 0 && n < CAPACITY + 100) begin
      step();
      n++;
    end
    checkOutput("t2_drained", pop_count, CAPACITY);
    checkOutput("t2_level_empty", LEVEL, 0);

    // Full-rate streaming
    clearCounters();
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    n = 0;
    while (model_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    checkOutput("t3_accepted", acc_count, 1000);
    checkOutput("t3_popped", pop_count, 1000);
    checkOutput("t3_latency", first_pop_cyc - first_acc_cyc, 3);
    checkOutput("t3_no_gaps", last_pop_cyc - first_pop_cyc, 999);

    // Random traffic across pointer wrap
    clearCounters();
    n = 0;
    while ((acc_count < 20000 || model_q.size() != 0) && n < 55000) begin
      applyStimulus((acc_count < 20000) ? 1'($urandom_range(0, 1)) : 1'b0,
                    8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      step();
      n++;
    end
    checkOutput("t4_accepted", acc_count, 20000);
    checkOutput("t4_popped", pop_count, 20000);

    // FLUSH with a read in flight
    clearCounters();
    n = 0;
    while (acc_count < 101 && n < 300) begin
      applyStimulus(1'b1, 8'(acc_count), 1'b0, 1'b0);
      step();
      n++;
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    checkOutput("t5_read_issued", s_r_en, 1);
    checkOutput("t5_level_100", LEVEL, 100);
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1);
    step();
    checkOutput("t5_flush_in_ready", s_in_ready, 0);
    checkOutput("t5_flush_w_en", s_w_en, 0);
    checkOutput("t5_flush_r_en", s_r_en, 0);
    checkOutput("t5_flush_level", LEVEL, 0);
    checkOutput("t5_flush_valid", OUT_VALID, 0);
    clearCounters();
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
    n = 0;
    while (acc_count == 0 && n < 10) begin
      step();
      n++;
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    n = 0;
    while (pop_count == 0 && n < 10) begin
      step();
      n++;
    end
    checkOutput("t5_next_word_pop", pop_count, 1);
    checkOutput("t5_next_word", last_pop_data, 8'h11);

    // Asynchronous reset mid-stream
    clearCounters();
    n = 0;
    while (acc_count < 500 && n < 1000) begin
      applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
      step();
      n++;
    end
    checkOutput("t6_level_500", LEVEL, 500);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    #2 RESET = 1'b1;
    #1;
    checkResetOutputs("t6_async");
    @(posedge CLK); #1;
    checkResetOutputs("t6_held");
    model_q.delete();
    stall_armed = 1'b0;
    RESET = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    checkOutput("t6_ready_release", IN_READY, 1);
    clearCounters();
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
    step();
    checkOutput("t6_accept", s_acc, 1);
    checkOutput("t6_w_addr", s_w_addr, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    n = 0;
    while (pop_count == 0 && n < 10) begin
      step();
      n++;
    end
    checkOutput("t6_roundtrip", last_pop_data, 8'h5A);
    checkOutput("t6_level_end", LEVEL, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
